// File: rtl/pb_emu_pkg.sv
// Shared types and constants for the pushbutton bounce emulator.
package pb_emu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_BOUNCE,
        S_HOLD,
        S_RELEASE_BOUNCE,
        S_DONE
    } pb_emu_state_t;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tick_gen_1khz.sv
// Free-running divider producing a one-clock tick every MAX_1kHz_div_count+1 clocks.
module tick_gen_1khz #(
    parameter int unsigned MAX_1kHz_div_count = 24999
) (
    input  logic CLOCK_50_I,
    input  logic resetn,
    output logic tick_o
);

    localparam int CNT_W = (MAX_1kHz_div_count > 0) ? $clog2(MAX_1kHz_div_count + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_1kHz_div_count);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pb_bounce_emulator.sv
// Drives active-low pushbutton lines with LFSR-driven contact bounce, one press per start request.
module pb_bounce_emulator
    import pb_emu_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS        = 4,
    parameter int unsigned MAX_1kHz_div_count = 24999,
    parameter logic [15:0] LFSR_SEED          = LFSR_SEED_DEFAULT
) (
    input  logic                           CLOCK_50_I,
    input  logic                           resetn,
    input  logic                           start_i,
    input  logic [$clog2(NUM_BUTTONS)-1:0] button_idx_i,
    input  logic [3:0]                     bounce_ms_i,
    input  logic [15:0]                    hold_ms_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [NUM_BUTTONS-1:0]         PUSH_BUTTON_N_O
);

    localparam int IDX_W = $clog2(NUM_BUTTONS);

    logic                   tick;
    pb_emu_state_t          state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [3:0]             bounce_q, bounce_d;
    logic [15:0]            hold_q, hold_d;
    logic [15:0]            ms_cnt_q, ms_cnt_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [NUM_BUTTONS-1:0] lines_q, lines_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [15:0]            ms_inc;

    tick_gen_1khz #(
        .MAX_1kHz_div_count(MAX_1kHz_div_count)
    ) u_tick_gen (
        .CLOCK_50_I(CLOCK_50_I),
        .resetn    (resetn),
        .tick_o    (tick)
    );

    assign ms_inc = ms_cnt_q + 16'd1;

    // NOTE: every _d gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bounce_d = bounce_q;
        hold_d   = hold_q;
        ms_cnt_d = ms_cnt_q;
        lines_d  = lines_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        lfsr_d   = tick ? lfsr_next(lfsr_q) : lfsr_q;

        case (state_q)
            S_IDLE: begin
                lines_d = '1;
                busy_d  = 1'b0;
                if (start_i) begin
                    idx_d                 = button_idx_i;
                    bounce_d              = bounce_ms_i;
                    hold_d                = (hold_ms_i == 16'd0) ? 16'd1 : hold_ms_i;
                    ms_cnt_d              = 16'd0;
                    lines_d[button_idx_i] = 1'b0;
                    busy_d                = 1'b1;
                    state_d               = (bounce_ms_i == 4'd0) ? S_HOLD : S_PRESS_BOUNCE;
                end
            end
            S_PRESS_BOUNCE: if (tick) begin
                ms_cnt_d = ms_inc;
                if (ms_inc == {12'd0, bounce_q}) begin
                    lines_d[idx_q] = 1'b0;
                    ms_cnt_d       = 16'd0;
                    state_d        = S_HOLD;
                end else begin
                    lines_d[idx_q] = lfsr_q[0];
                end
            end
            S_HOLD: if (tick) begin
                ms_cnt_d = ms_inc;
                if (ms_inc == hold_q) begin
                    lines_d[idx_q] = 1'b1;
                    ms_cnt_d       = 16'd0;
                    if (bounce_q == 4'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RELEASE_BOUNCE;
                    end
                end
            end
            S_RELEASE_BOUNCE: if (tick) begin
                ms_cnt_d = ms_inc;
                if (ms_inc == {12'd0, bounce_q}) begin
                    lines_d[idx_q] = 1'b1;
                    ms_cnt_d       = 16'd0;
                    state_d        = S_DONE;
                    done_d         = 1'b1;
                end else begin
                    lines_d[idx_q] = lfsr_q[0];
                end
            end
            S_DONE: begin
                lines_d = '1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                lines_d = '1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            bounce_q <= '0;
            hold_q   <= 16'd1;
            ms_cnt_q <= '0;
            lfsr_q   <= LFSR_SEED;
            lines_q  <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bounce_q <= bounce_d;
            hold_q   <= hold_d;
            ms_cnt_q <= ms_cnt_d;
            lfsr_q   <= lfsr_d;
            lines_q  <= lines_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign PUSH_BUTTON_N_O = lines_q;

endmodule

// File: tb/tb_pb_bounce_emulator.sv
// Randomized bench for pb_bounce_emulator against a tick-count reference model (tick every 5 clocks).
module tb_pb_bounce_emulator;

    localparam int unsigned MAX_DIV = 4;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  idx;
    logic [3:0]  bounce;
    logic [15:0] hold;
    logic        busy;
    logic        done;
    logic [3:0]  pb;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 0;

    pb_bounce_emulator #(
        .NUM_BUTTONS       (4),
        .MAX_1kHz_div_count(MAX_DIV),
        .LFSR_SEED         (16'hACE1)
    ) dut (
        .CLOCK_50_I     (clk),
        .resetn         (resetn),
        .start_i        (start),
        .button_idx_i   (idx),
        .bounce_ms_i    (bounce),
        .hold_ms_i      (hold),
        .busy_o         (busy),
        .done_o         (done),
        .PUSH_BUTTON_N_O(pb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a press is a run of 2*bounce+max(hold,1) ticks counted from the accepted start.
    typedef struct packed {
        bit          active;
        bit          done;
        bit          busy;
        int          n;
        int          idx;
        int          b;
        int          h;
        int          div;
        logic [15:0] lfsr;
        logic [3:0]  lines;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r        = '0;
        r.lines  = 4'hF;
        r.lfsr   = 16'hACE1;
        return r;
    endfunction

    function automatic model_t model_step(model_t c, logic st, logic [1:0] ix,
                                          logic [3:0] bo, logic [15:0] ho);
        model_t r     = c;
        bit     tk    = (c.div == int'(MAX_DIV));
        int     total = 2 * c.b + c.h;
        if (c.done) begin
            r.done  = 1'b0;
            r.busy  = 1'b0;
            r.lines = 4'hF;
        end else if (!c.active) begin
            if (st) begin
                r.active    = 1'b1;
                r.busy      = 1'b1;
                r.idx       = int'(ix);
                r.b         = int'(bo);
                r.h         = (ho == 16'd0) ? 1 : int'(ho);
                r.n         = 0;
                r.lines     = 4'hF;
                r.lines[ix] = 1'b0;
            end
        end else if (tk) begin
            r.n = c.n + 1;
            if (r.n <= c.b)
                r.lines[c.idx] = (r.n == c.b) ? 1'b0 : c.lfsr[0];
            else if (r.n <= c.b + c.h)
                r.lines[c.idx] = (r.n == c.b + c.h);
            else
                r.lines[c.idx] = (r.n == total) ? 1'b1 : c.lfsr[0];
            if (r.n == total) begin
                r.active = 1'b0;
                r.done   = 1'b1;
            end
        end
        r.div = tk ? 0 : c.div + 1;
        if (tk) r.lfsr = {c.lfsr[14:0], c.lfsr[15] ^ c.lfsr[13] ^ c.lfsr[12] ^ c.lfsr[10]};
        return r;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m <= model_reset();
        else         m <= model_step(m, start, idx, bounce, hold);
    end

    always @(negedge clk) begin
        if (resetn && mon_en) begin
            check("lines", 32'(pb), 32'(m.lines));
            check("busy", 32'(busy), 32'(m.busy));
            check("done", 32'(done), 32'(m.done));
        end
    end

    // Issues one request and returns the number of clocks busy_o stayed high.
    task automatic do_press(input logic [1:0] ix, input logic [3:0] bo, input logic [15:0] ho,
                            output int span);
        @(negedge clk);
        start  = 1'b1;
        idx    = ix;
        bounce = bo;
        hold   = ho;
        @(negedge clk);
        start = 1'b0;
        span  = 0;
        while (busy && span < 2000) begin
            span++;
            @(negedge clk);
        end
        if (span >= 2000) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    int span;
    int waited;

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        idx    = '0;
        bounce = '0;
        hold   = '0;
        repeat (3) @(negedge clk);
        check("rst_lines", 32'(pb), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        resetn = 1'b1;
        mon_en = 1'b1;

        // Clean edges: 3 hold ticks, start phase within one tick period.
        do_press(2'd2, 4'd0, 16'd3, span);
        check("t2_span_ok", 32'(span >= 12 && span <= 16), 32'd1);

        // Bounce on both edges: 4+10+4 ticks.
        do_press(2'd0, 4'd4, 16'd10, span);
        check("t3_span_ok", 32'(span >= 87 && span <= 91), 32'd1);

        // Starts while busy (mid-HOLD and on the DONE clock) must be dropped.
        @(negedge clk);
        start = 1'b1; idx = 2'd1; bounce = 4'd1; hold = 16'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        start = 1'b1; idx = 2'd3; bounce = 4'd7; hold = 16'd2;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!done && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        check("t4_done_seen", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_idle_after_done", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // Reset in the middle of HOLD.
        @(negedge clk);
        start = 1'b1; idx = 2'd3; bounce = 4'd2; hold = 16'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("t5_pressed", 32'(pb), 32'h7);
        resetn = 1'b0;
        #1;
        check("t5_rst_lines", 32'(pb), 32'hF);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        do_press(2'd3, 4'd1, 16'd2, span);
        check("t5_rerun_span_ok", 32'(span >= 17 && span <= 21), 32'd1);

        // Random traffic, including starts and input changes while busy.
        repeat (4000) begin
            @(negedge clk);
            start  = ($urandom_range(0, 7) == 0);
            idx    = 2'($urandom_range(0, 3));
            bounce = 4'($urandom_range(0, 6));
            hold   = 16'($urandom_range(0, 15));
        end
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (busy && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        check("final_idle", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
